mont_cond_sub: RTL

Word-serial final conditional subtraction stage for MonPro. Consumes the Montgomery intermediate result T streamed least-significant word first, together with its top carry bit. Computes T − N word by word alongside the load, then streams out either T − N (when T ≥ N) or T unchanged. Sits downstream of the multiply-add array, as the consumer of its word outputs, and produces the reduced MonPro result.

---
 rtl/mont_cond_sub.sv | 106 ++++++++++
 1 files changed

// File: rtl/mont_cond_sub.sv
// Word-serial final conditional subtraction for MonPro: buffers T and T-N while T streams in,
// then streams out T-N when T >= N (carry word included), otherwise T unchanged.
module mont_cond_sub #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_word,
   input  logic                          in_carry,
   output logic [$clog2(NUM_WORDS)-1:0]  n_addr,
   input  logic [DATA_WIDTH-1:0]         n_word,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_word,
   output logic                          out_last,
   output logic                          subtracted
);

   localparam int unsigned AW = $clog2(NUM_WORDS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {StLoad, StDecide, StSend} state_t;

   state_t              state;
   logic [AW-1:0]       in_cnt;
   logic [AW-1:0]       out_cnt;
   logic [AW-1:0]       nxt_cnt;
   logic                borrow;
   logic                carry_r;
   logic                sel;
   logic [DATA_WIDTH:0] diff;

   logic [DATA_WIDTH-1:0] t_buf [NUM_WORDS];
   logic [DATA_WIDTH-1:0] d_buf [NUM_WORDS];

   assign in_ready = (state == StLoad);
   assign n_addr   = (state == StLoad) ? in_cnt : '0;
   assign diff     = {1'b0, in_word} - {1'b0, n_word} - {{DATA_WIDTH{1'b0}}, borrow};
   // A set carry word means T exceeds N regardless of the final borrow.
   assign sel      = carry_r | ~borrow;
   assign nxt_cnt  = out_cnt + AW'(1);

   // Buffers carry no reset; a discarded partial frame is simply overwritten.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         t_buf[in_cnt] <= in_word;
         d_buf[in_cnt] <= diff[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StLoad;
         in_cnt     <= '0;
         out_cnt    <= '0;
         borrow     <= 1'b0;
         carry_r    <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_word   <= '0;
         subtracted <= 1'b0;
      end else begin
         unique case (state)
            StLoad: begin
               if (in_valid) begin
                  borrow <= diff[DATA_WIDTH];
                  in_cnt <= in_cnt + AW'(1);
                  if (in_cnt == '0) subtracted <= 1'b0;
                  if (in_cnt == LAST_IDX) begin
                     carry_r <= in_carry;
                     state   <= StDecide;
                  end
               end
            end
            StDecide: begin
               subtracted <= sel;
               out_word   <= sel ? d_buf[0] : t_buf[0];
               out_cnt    <= '0;
               out_valid  <= 1'b1;
               out_last   <= (NUM_WORDS == 1);
               in_cnt     <= '0;
               borrow     <= 1'b0;
               state      <= StSend;
            end
            StSend: begin
               if (out_valid && out_ready) begin
                  if (out_cnt == LAST_IDX) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= StLoad;
                  end else begin
                     out_cnt  <= nxt_cnt;
                     out_word <= subtracted ? d_buf[nxt_cnt] : t_buf[nxt_cnt];
                     out_last <= (nxt_cnt == LAST_IDX);
                  end
               end
            end
            default: state <= StLoad;
         endcase
      end
   end

endmodule
